bcd_conv_scheduler: RTL

Shares one binary-to-BCD converter (8-bit in, 3-digit packed BCD out, registered, valid for inputs 0..199) between NUM_REQ requesters, e.g. the Bluetooth-commanded servo angle and the measured servo position feeding the display.
- Arbitrates requests round-robin.
- Holds the converter input stable for the converter's settling latency.
- Captures the BCD result and returns it with the requester ID over a valid/ready response channel.
- Rejects out-of-range values without using the converter.

---
 rtl/bcd_conv_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one registered binary-to-BCD converter between
// NUM_REQ requesters. A granted value is driven to the converter and held while
// the converter settles. The captured BCD result is then returned with the
// requester ID over a valid/ready response channel. Values above 199 are
// rejected with an error response and never reach the converter.
module bcd_conv_scheduler #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CONV_LATENCY = 2,
    parameter int unsigned ID_W         = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Hex,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [7:0]           o_Conv_Hex,
    input  logic [11:0]          i_Conv_Dec,
    output logic                 o_Resp_Valid,
    input  logic                 i_Resp_Ready,
    output logic [ID_W-1:0]      o_Resp_Id,
    output logic [11:0]          o_Resp_Dec,
    output logic                 o_Resp_Err,
    output logic                 o_Busy
);

    localparam int unsigned CNT_W = (CONV_LATENCY < 1) ? 1 : $clog2(CONV_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StHold, StResp} t_state;

    t_state             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_conv_hex, w_conv_hex_nxt;
    logic [ID_W-1:0]    r_resp_id, w_resp_id_nxt;
    logic [11:0]        r_resp_dec, w_resp_dec_nxt;
    logic               r_resp_err, w_resp_err_nxt;

    logic               w_grant_found;
    logic [ID_W-1:0]    w_grant_idx;
    logic [7:0]         w_grant_val;
    logic [NUM_REQ-1:0] w_mask;
    int unsigned        w_idx;

    // Find the first valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        w_mask        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx  = (32'(r_ptr) + i) % NUM_REQ;
            w_mask = NUM_REQ'(1) << w_idx;
            if (!w_grant_found && ((i_Req_Valid & w_mask) != '0)) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(w_idx);
            end
        end
        w_grant_val = 8'(i_Req_Hex >> {w_grant_idx, 3'b000});
    end

    // Next-state and datapath updates for the IDLE/HOLD/RESP sequence.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_conv_hex_nxt = r_conv_hex;
        w_resp_id_nxt  = r_resp_id;
        w_resp_dec_nxt = r_resp_dec;
        w_resp_err_nxt = r_resp_err;
        o_Req_Ready    = '0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_found) begin
                    o_Req_Ready   = NUM_REQ'(1) << w_grant_idx;
                    w_resp_id_nxt = w_grant_idx;
                    w_ptr_nxt     = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : w_grant_idx + 1'b1;
                    if (w_grant_val <= 8'd199) begin
                        w_conv_hex_nxt = w_grant_val;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = StHold;
                    end else begin
                        // Out of range: answer immediately, converter input untouched.
                        w_resp_dec_nxt = '0;
                        w_resp_err_nxt = 1'b1;
                        w_state_nxt    = StResp;
                    end
                end
            end
            StHold: begin
                if (r_cnt == CNT_W'(CONV_LATENCY)) begin
                    w_resp_dec_nxt = i_Conv_Dec;
                    w_resp_err_nxt = 1'b0;
                    w_state_nxt    = StResp;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StResp: begin
                if (i_Resp_Ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_conv_hex <= '0;
            r_resp_id  <= '0;
            r_resp_dec <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_conv_hex <= w_conv_hex_nxt;
            r_resp_id  <= w_resp_id_nxt;
            r_resp_dec <= w_resp_dec_nxt;
            r_resp_err <= w_resp_err_nxt;
        end
    end

    assign o_Conv_Hex   = r_conv_hex;
    assign o_Resp_Id    = r_resp_id;
    assign o_Resp_Dec   = r_resp_dec;
    assign o_Resp_Err   = r_resp_err;
    assign o_Resp_Valid = (r_state == StResp);
    assign o_Busy       = (r_state != StIdle);

endmodule
